counter_sequencer: RTL and testbench
====================================

// Module: counter_sequencer
//
// PURPOSE
//  Controller for the WIDTH-bit up-counter datapath: runs the count from 0 to a programmed limit,
//  one-shot or periodic, with pause and abort. Sits beside the flip-flop/counter primitives and
//  produces the tick/done events that downstream sequential logic uses as its timebase.
//
// PARAMETERS
//  WIDTH  4  counter and limit width in bits; limit range 0 .. 2**WIDTH-1
//
// PORTS
//  clk       in   1      single clock, all state updates on rising edge
//  rst       in   1      synchronous reset, active-high
//  start     in   1      start request; sampled only in IDLE
//  stop      in   1      abort request; highest priority after rst
//  pause     in   1      level: freeze count while high (RUN<->HOLD)
//  periodic  in   1      mode sampled with start: 1 = periodic, 0 = one-shot
//  limit     in   WIDTH  terminal count, sampled with start
//  count     out  WIDTH  current count value (registered)
//  busy      out  1      1 when state != IDLE (registered)
//  tick      out  1      one-cycle pulse each time the count reaches limit (registered)
//  done      out  1      one-cycle pulse at one-shot completion (registered)
//
// BEHAVIOUR
//  - Reset (sync, active-high): state=IDLE, count=0, busy=0, tick=0, done=0, limit_q=0, periodic_q=0.
//  - FSM states: IDLE, RUN, HOLD. Priority each edge: rst > stop > pause > start/count.
//  - tick and done default to 0 every cycle; each is high for exactly one cycle when set.
//  - IDLE: start=1 & stop=0 -> limit_q<=limit, periodic_q<=periodic, count<=0, RUN.
//    start & stop together -> stay IDLE. count holds its last value in IDLE.
//  - RUN, stop=1 -> IDLE, count<=0; no tick, no done.
//  - RUN, pause=1 -> HOLD, count frozen; terminal check deferred (pause beats terminal).
//  - RUN, count!=limit_q -> count<=count+1.
//  - RUN, count==limit_q -> tick<=1;
//    if periodic_q: count<=0, stay RUN;
//    else: done<=1, count holds limit_q, go IDLE.
//  - HOLD: stop=1 -> IDLE, count<=0. pause=0 -> RUN. Otherwise stay HOLD.
//    No tick and no done while in HOLD.
//  - start is ignored in RUN and HOLD; no restart and no relatch of limit/periodic.
//  - limit/periodic changes after start have no effect until the next start from IDLE.
//  - Timing: start at edge N -> count=0 and busy=1 after N.
//    Unpaused, tick is visible after edge N+limit_q+1.
//    Periodic period is limit_q+1 cycles.
//  - limit=0: count stays 0; tick each cycle in periodic mode.
//    One-shot: tick+done after N+1.
//  - count never exceeds limit_q; no wrap at 2**WIDTH-1. limit=all-ones counts the full range.
//  - busy mirrors the registered state: it drops in the same cycle done rises.
//
// TESTING
//  1. Reset: rst=1 for 2 edges mid-RUN -> count=0, busy=0, tick=0, done=0 next cycle.
//  2. One-shot limit=3: start pulse -> count 0,1,2,3; tick=done=1 for one cycle; busy=0; count holds 3.
//  3. Periodic limit=2: tick every 3 cycles for >=3 periods; count 0,1,2,0,...; done never asserts.
//  4. Pause: limit=5, pause 3 cycles at count=2 -> count holds 2 in HOLD, resumes 3;
//     tick delayed by exactly 3 cycles.
//  5. Stop/priority:
//     stop in RUN at count=4 -> IDLE, count=0, no tick/done;
//     start+stop in IDLE -> stays IDLE;
//     pause while count==limit -> no tick until pause releases.
//  6. Edges:
//     limit=0 periodic -> tick every cycle;
//     limit=15 one-shot -> 16-cycle run with no wrap;
//     start during RUN -> ignored, limit not relatched.

Source files
------------

// File: rtl/counter_sequencer.sv
// Purpose: sequences a WIDTH-bit up-count from 0 to a latched limit, one-shot or periodic, with pause/abort.
// Latency: start -> count=0/busy=1 one cycle later; tick limit_q+1 cycles after start when unpaused.
// Backpressure: pause level freezes the count (RUN->HOLD); stop aborts to IDLE; start is ignored while busy.
//
// Ports:
//   clk, rst            single rising-edge clock, synchronous active-high reset
//   start, stop, pause  start request (IDLE only), abort, count freeze
//   periodic, limit     run mode and terminal count, latched together with start
//   count, busy         current count and "not idle", both registered
//   tick, done          one-cycle pulses: count reached limit / one-shot finished
module counter_sequencer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             periodic,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             tick,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] limit_q;
    logic             periodic_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            count      <= '0;
            busy       <= 1'b0;
            tick       <= 1'b0;
            done       <= 1'b0;
            limit_q    <= '0;
            periodic_q <= 1'b0;
        end else begin
            // Event outputs are pulses: cleared unless set again below.
            tick <= 1'b0;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // count deliberately keeps its last value while idle.
                    if (start && !stop) begin
                        limit_q    <= limit;
                        periodic_q <= periodic;
                        count      <= '0;
                        state      <= RUN;
                        busy       <= 1'b1;
                    end
                end
                RUN: begin
                    if (stop) begin
                        count <= '0;
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (pause) begin
                        // Pause wins over the terminal check; it is re-evaluated after resume.
                        state <= HOLD;
                    end else if (count != limit_q) begin
                        count <= count + WIDTH'(1);
                    end else begin
                        tick <= 1'b1;
                        if (periodic_q) begin
                            count <= '0;
                        end else begin
                            done  <= 1'b1;
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                HOLD: begin
                    if (stop) begin
                        count <= '0;
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (!pause) begin
                        // Resuming costs one edge; counting restarts on the following one.
                        state <= RUN;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_counter_sequencer.sv
// Purpose: self-checking bench for counter_sequencer against a step-count reference model.
// Latency: model advances on every rising edge; outputs compared 1 time unit later.
// Backpressure: not applicable; all inputs driven directly by the bench.
module tb_counter_sequencer;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         stop;
    logic         pause;
    logic         periodic;
    logic [W-1:0] limit;
    logic [W-1:0] count;
    logic         busy;
    logic         tick;
    logic         done;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a run is "number of counting edges since start".
    bit m_active;
    bit m_held;
    int m_steps;
    int m_lim;
    bit m_per;
    int m_count;
    bit m_tick;
    bit m_done;

    counter_sequencer #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stop     (stop),
        .pause    (pause),
        .periodic (periodic),
        .limit    (limit),
        .count    (count),
        .busy     (busy),
        .tick     (tick),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_edge();
        m_tick = 1'b0;
        m_done = 1'b0;
        if (rst) begin
            m_active = 1'b0; m_held = 1'b0; m_steps = 0;
            m_lim = 0; m_per = 1'b0; m_count = 0;
        end else if (!m_active) begin
            if (start && !stop) begin
                m_active = 1'b1; m_held = 1'b0; m_steps = 0;
                m_lim = int'(limit); m_per = periodic; m_count = 0;
            end
        end else if (stop) begin
            m_active = 1'b0;
            m_count  = 0;
        end else if (m_held) begin
            if (!pause) m_held = 1'b0;
        end else if (pause) begin
            m_held = 1'b1;
        end else begin
            // Every (limit+1)-th counting edge is a terminal edge.
            m_steps++;
            if (m_steps % (m_lim + 1) == 0) m_tick = 1'b1;
            if (m_per) begin
                m_count = m_steps % (m_lim + 1);
            end else if (m_steps > m_lim) begin
                m_count  = m_lim;
                m_done   = 1'b1;
                m_active = 1'b0;
            end else begin
                m_count = m_steps;
            end
        end
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("count", 32'(count), 32'(m_count));
        check("busy",  32'(busy),  32'(m_active));
        check("tick",  32'(tick),  32'(m_tick));
        check("done",  32'(done),  32'(m_done));
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Steps until tick is seen; returns the number of edges taken (max+1 if never seen).
    task automatic wait_tick(input int max, output int n);
        n = 0;
        while (n < max) begin
            step();
            n++;
            if (tick) return;
        end
        n = max + 1;
    endtask

    task automatic kick(input int lim, input bit per);
        limit = W'(lim); periodic = per; start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic abort();
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    initial begin
        int n;
        rst = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0;
        periodic = 1'b0; limit = '0;
        steps(2);
        check("reset_count", 32'(count), 32'd0);
        check("reset_busy",  32'(busy),  32'd0);
        rst = 1'b0;
        step();

        // One-shot, limit 3: tick+done four edges after the start edge, then count holds 3.
        kick(3, 1'b0);
        wait_tick(20, n);
        check("oneshot_lat", 32'(n), 32'd4);
        check("oneshot_done", 32'(done), 32'd1);
        check("oneshot_busy", 32'(busy), 32'd0);
        steps(3);
        check("oneshot_hold", 32'(count), 32'd3);

        // Periodic, limit 2: period of 3 edges, never done.
        kick(2, 1'b1);
        wait_tick(20, n);
        check("per_first", 32'(n), 32'd3);
        for (int p = 0; p < 3; p++) begin
            wait_tick(20, n);
            check("per_period", 32'(n), 32'd3);
        end
        abort();

        // Reset held two edges in the middle of a run.
        kick(9, 1'b0);
        steps(3);
        rst = 1'b1;
        steps(2);
        rst = 1'b0;
        check("midrun_rst_count", 32'(count), 32'd0);
        check("midrun_rst_busy",  32'(busy),  32'd0);
        step();

        // Pause at count 2 for two edges: HOLD for two cycles plus the resume edge,
        // so the tick arrives 3 cycles later than the unpaused 6.
        kick(5, 1'b0);
        steps(2);
        pause = 1'b1;
        steps(2);
        check("hold_count", 32'(count), 32'd2);
        pause = 1'b0;
        wait_tick(20, n);
        check("pause_resume_lat", 32'(n), 32'd5);

        // Stop at count 4.
        kick(9, 1'b0);
        steps(4);
        check("pre_stop_count", 32'(count), 32'd4);
        abort();
        check("stop_count", 32'(count), 32'd0);
        check("stop_busy",  32'(busy),  32'd0);

        // start and stop together in IDLE.
        start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        check("start_stop_idle", 32'(busy), 32'd0);

        // Pause while sitting on the terminal count defers the tick.
        kick(2, 1'b0);
        steps(2);
        pause = 1'b1;
        steps(3);
        pause = 1'b0;
        wait_tick(20, n);
        check("pause_at_limit_lat", 32'(n), 32'd2);

        // limit 0 periodic: tick every cycle.
        kick(0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step();
            check("lim0_tick", 32'(tick), 32'd1);
        end
        abort();

        // Full range one-shot: 16 edges, no wrap.
        kick(15, 1'b0);
        wait_tick(40, n);
        check("full_range_lat", 32'(n), 32'd16);
        check("full_range_count", 32'(count), 32'd15);

        // start during RUN with a new limit/mode is ignored.
        kick(4, 1'b0);
        limit = 4'd9; periodic = 1'b1; start = 1'b1;
        steps(2);
        start = 1'b0;
        wait_tick(20, n);
        check("no_relatch_lat", 32'(n), 32'd3);
        check("no_relatch_done", 32'(done), 32'd1);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            rst      = ($urandom_range(199) == 0);
            start    = ($urandom_range(3) == 0);
            stop     = ($urandom_range(49) == 0);
            pause    = ($urandom_range(9) < 2);
            periodic = $urandom_range(1);
            limit    = W'($urandom_range(15));
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
